// File: rtl/cache_controller.sv
// Cache controller: sequences a 2-way, 64-set data cache (two 32-bit words per line)
// between the MEM stage and the SRAM controller.
//   - Read hits are served combinationally from the cache in the same cycle.
//   - Read misses fetch a 64-bit line from SRAM, fill the cache and forward the word.
//   - Writes are write-through, no-write-allocate: invalidate the line, then write SRAM.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   address, wdata               processor byte address / store data
//   MEM_R_EN, MEM_W_EN           load / store request, held until ready
//   rdata, ready                 load data and access-complete handshake
//   cache_*                      address, strobes and fill data to/from the cache
//   sram_*                       line-read / word-write requests to the SRAM controller
//   hit_count, miss_count        saturating read hit / miss counters
module cache_controller #(
  parameter int unsigned ADDR_OFFSET = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      address,
  input  logic [31:0]      wdata,
  input  logic             MEM_R_EN,
  input  logic             MEM_W_EN,
  output logic [31:0]      rdata,
  output logic             ready,
  output logic [18:0]      cache_addr,
  output logic             cache_R_EN,
  output logic             cache_W_EN,
  output logic             cache_invalidate,
  output logic [63:0]      cache_wdata,
  input  logic             cache_hit,
  input  logic [31:0]      cache_rdata,
  output logic             sram_rd_en,
  output logic             sram_wr_en,
  output logic [18:0]      sram_addr,
  output logic [31:0]      sram_wdata,
  input  logic [63:0]      sram_rdata,
  input  logic             sram_ready,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {
    StIdle,
    StReadMiss,
    StWrite
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic [CNT_W-1:0] miss_count_q, miss_count_d;

  logic [31:0] eff;
  logic [18:0] line_addr;
  logic        unused_eff_hi;

  assign eff           = address - 32'(ADDR_OFFSET);
  assign line_addr     = {eff[18:3], 3'b000};
  assign unused_eff_hi = ^eff[31:19];

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

  always_comb begin
    state_d          = state_q;
    hit_count_d      = hit_count_q;
    miss_count_d     = miss_count_q;
    rdata            = '0;
    ready            = 1'b0;
    cache_addr       = eff[18:0];
    cache_R_EN       = 1'b0;
    cache_W_EN       = 1'b0;
    cache_invalidate = 1'b0;
    cache_wdata      = sram_rdata;
    sram_rd_en       = 1'b0;
    sram_wr_en       = 1'b0;
    sram_addr        = eff[18:0];
    sram_wdata       = wdata;

    // Reset forces every handshake low so nothing leaks out during the reset cycle.
    if (rst) begin
      state_d      = StIdle;
      hit_count_d  = '0;
      miss_count_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (MEM_W_EN) begin
            // Store wins over a simultaneous load.
            cache_invalidate = 1'b1;
            sram_wr_en       = 1'b1;
            state_d          = StWrite;
          end else if (MEM_R_EN) begin
            if (cache_hit) begin
              ready      = 1'b1;
              rdata      = cache_rdata;
              cache_R_EN = 1'b1;
              if (hit_count_q != '1) hit_count_d = hit_count_q + CNT_W'(1);
            end else begin
              sram_rd_en = 1'b1;
              sram_addr  = line_addr;
              if (miss_count_q != '1) miss_count_d = miss_count_q + CNT_W'(1);
              state_d    = StReadMiss;
            end
          end else begin
            ready = 1'b1;
          end
        end
        StReadMiss: begin
          sram_rd_en = 1'b1;
          sram_addr  = line_addr;
          if (sram_ready) begin
            cache_W_EN = 1'b1;
            rdata      = eff[2] ? sram_rdata[63:32] : sram_rdata[31:0];
            ready      = 1'b1;
            state_d    = StIdle;
          end
        end
        StWrite: begin
          sram_wr_en = 1'b1;
          if (sram_ready) begin
            ready   = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed self-checking bench for cache_controller.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address, wdata;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] rdata;
  logic        ready;
  logic [18:0] cache_addr;
  logic        cache_R_EN, cache_W_EN, cache_invalidate;
  logic [63:0] cache_wdata;
  logic        cache_hit;
  logic [31:0] cache_rdata;
  logic        sram_rd_en, sram_wr_en;
  logic [18:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;
  logic [15:0] hit_count, miss_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cache_controller #(
    .ADDR_OFFSET(1024),
    .CNT_W      (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .address         (address),
    .wdata           (wdata),
    .MEM_R_EN        (MEM_R_EN),
    .MEM_W_EN        (MEM_W_EN),
    .rdata           (rdata),
    .ready           (ready),
    .cache_addr      (cache_addr),
    .cache_R_EN      (cache_R_EN),
    .cache_W_EN      (cache_W_EN),
    .cache_invalidate(cache_invalidate),
    .cache_wdata     (cache_wdata),
    .cache_hit       (cache_hit),
    .cache_rdata     (cache_rdata),
    .sram_rd_en      (sram_rd_en),
    .sram_wr_en      (sram_wr_en),
    .sram_addr       (sram_addr),
    .sram_wdata      (sram_wdata),
    .sram_rdata      (sram_rdata),
    .sram_ready      (sram_ready),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    address     = 32'd1024;
    wdata       = '0;
    MEM_R_EN    = 1'b0;
    MEM_W_EN    = 1'b0;
    cache_hit   = 1'b0;
    cache_rdata = '0;
    sram_rdata  = '0;
    sram_ready  = 1'b0;
    step();
    step();
    check("rst_ready", ready, 0);
    check("rst_rdata", rdata, 0);
    check("rst_strobes", {cache_R_EN, cache_W_EN, cache_invalidate, sram_rd_en, sram_wr_en}, 0);
    check("rst_hits", hit_count, 0);
    check("rst_misses", miss_count, 0);

    rst = 1'b0;
    #1;
    check("idle_ready", ready, 1);

    // Read miss, word 0.
    address  = 32'd1024 + 32'h10;
    MEM_R_EN = 1'b1;
    #1;
    check("miss_ready", ready, 0);
    check("miss_rd_en", sram_rd_en, 1);
    check("miss_sram_addr", sram_addr, 19'h10);
    check("miss_cache_addr", cache_addr, 19'h10);
    step();
    check("miss_count1", miss_count, 1);
    check("rm_rd_en", sram_rd_en, 1);
    check("rm_ready", ready, 0);
    step();
    check("rm_no_recount", miss_count, 1);
    check("rm_wen_wait", cache_W_EN, 0);
    sram_rdata = 64'hBBBB_BBBB_AAAA_AAAA;
    sram_ready = 1'b1;
    #1;
    check("fill_wen", cache_W_EN, 1);
    check("fill_ren", cache_R_EN, 0);
    check("fill_wdata", cache_wdata, 64'hBBBB_BBBB_AAAA_AAAA);
    check("fill_rdata", rdata, 32'hAAAA_AAAA);
    check("fill_ready", ready, 1);
    step();
    sram_ready = 1'b0;
    MEM_R_EN   = 1'b0;
    #1;
    check("after_fill_ready", ready, 1);
    check("after_fill_rd_en", sram_rd_en, 0);

    // Read miss, word 1 of line 0x18.
    address  = 32'd1024 + 32'h1C;
    MEM_R_EN = 1'b1;
    #1;
    check("miss2_sram_addr", sram_addr, 19'h18);
    step();
    sram_rdata = 64'h1111_2222_3333_4444;
    sram_ready = 1'b1;
    #1;
    check("fill2_rdata", rdata, 32'h1111_2222);
    step();
    sram_ready = 1'b0;
    MEM_R_EN   = 1'b0;
    check("miss_count2", miss_count, 2);

    // Read hit.
    address     = 32'd1024 + 32'h14;
    MEM_R_EN    = 1'b1;
    cache_hit   = 1'b1;
    cache_rdata = 32'h1234_5678;
    #1;
    check("hit_ready", ready, 1);
    check("hit_rdata", rdata, 32'h1234_5678);
    check("hit_ren", cache_R_EN, 1);
    check("hit_no_sram", {sram_rd_en, sram_wr_en}, 0);
    step();
    MEM_R_EN  = 1'b0;
    cache_hit = 1'b0;
    check("hit_count1", hit_count, 1);

    // Store with 5-cycle SRAM latency.
    address  = 32'd1024 + 32'h20;
    wdata    = 32'hDEAD_BEEF;
    MEM_W_EN = 1'b1;
    #1;
    check("st_inval", cache_invalidate, 1);
    check("st_wr_en", sram_wr_en, 1);
    check("st_ready", ready, 0);
    check("st_sram_addr", sram_addr, 19'h20);
    check("st_sram_wdata", sram_wdata, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      step();
      check("wr_inval_low", cache_invalidate, 0);
      check("wr_held", {sram_wr_en, ready}, 2'b10);
    end
    step();
    sram_ready = 1'b1;
    #1;
    check("wr_done_ready", ready, 1);
    step();
    sram_ready = 1'b0;
    MEM_W_EN   = 1'b0;
    #1;
    check("wr_idle", {ready, sram_wr_en}, 2'b10);

    // Simultaneous load and store: store path wins.
    address   = 32'd1024 + 32'h24;
    MEM_R_EN  = 1'b1;
    MEM_W_EN  = 1'b1;
    cache_hit = 1'b1;
    #1;
    check("both_ren", cache_R_EN, 0);
    check("both_inval", cache_invalidate, 1);
    check("both_ready", ready, 0);
    step();
    sram_ready = 1'b1;
    #1;
    check("both_done", ready, 1);
    step();
    sram_ready = 1'b0;
    MEM_R_EN   = 1'b0;
    MEM_W_EN   = 1'b0;
    cache_hit  = 1'b0;
    check("both_counts", {hit_count, miss_count}, {16'd1, 16'd2});

    // Reset while a line read is outstanding.
    address  = 32'd1024 + 32'h40;
    MEM_R_EN = 1'b1;
    step();
    check("pre_rst_rd_en", sram_rd_en, 1);
    rst = 1'b1;
    step();
    rst      = 1'b0;
    MEM_R_EN = 1'b0;
    #1;
    check("post_rst_rd_en", sram_rd_en, 0);
    check("post_rst_ready", ready, 1);
    check("post_rst_counts", {hit_count, miss_count}, 0);
    sram_ready = 1'b1;
    #1;
    check("late_ready_no_wen", cache_W_EN, 0);
    step();
    sram_ready = 1'b0;

    // Hit counter saturation.
    address   = 32'd1024 + 32'h14;
    MEM_R_EN  = 1'b1;
    cache_hit = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    check("hit_fffe", hit_count, 16'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    check("hit_sat", hit_count, 16'hFFFF);
    check("sat_misses", miss_count, 0);
    MEM_R_EN  = 1'b0;
    cache_hit = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
